logicunit_pipe: RTL and testbench

Parametrised, two-stage pipelined W-bit logic unit with valid/ready handshakes on input and output. It extends the 1-bit, 2-bit-control logic unit to WIDTH bits, an 8-operation set, a registered zero flag and backpressure. It sits between operand fetch and writeback in the lab datapath and sustains one operation per cycle.

---
 rtl/logicunit_pkg.sv | 17 +
 rtl/logicunit_core.sv | 33 +++
 rtl/logicunit_pipe.sv | 92 +++++++++
 tb/tb_logicunit_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logicunit_pkg.sv
// logicunit_pkg: shared definitions for the pipelined logic unit.
// Defines the 3-bit operation type and the operation code constants
// used by logicunit_core and logicunit_pipe.
package logicunit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND   = 3'd0;  // a & b
  localparam op_t OP_OR    = 3'd1;  // a | b
  localparam op_t OP_XOR   = 3'd2;  // a ^ b
  localparam op_t OP_NOR   = 3'd3;  // ~(a | b)
  localparam op_t OP_ANDN  = 3'd4;  // a & ~b
  localparam op_t OP_ORN   = 3'd5;  // a | ~b
  localparam op_t OP_PASSA = 3'd6;  // a
  localparam op_t OP_NOTA  = 3'd7;  // ~a

endpackage

// File: rtl/logicunit_core.sv
// logicunit_core: combinational WIDTH-bit bitwise logic function.
// Ports:
//   a, b   : operands (WIDTH bits)
//   op     : operation select (logicunit_pkg op codes)
//   result : bitwise result of op applied to a and b (WIDTH bits)
module logicunit_core
  import logicunit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result
);

  // Operation decode: select the bitwise function of a and b.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (op)
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOR:   result = ~(a | b);
      OP_ANDN:  result = a & ~b;
      OP_ORN:   result = a | ~b;
      OP_PASSA: result = a;
      OP_NOTA:  result = ~a;
      default:  result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/logicunit_pipe.sv
// logicunit_pipe: two-stage pipelined WIDTH-bit logic unit with valid/ready
// handshakes. S1 registers the operands and op; S2 registers the result and
// its zero flag. Sustains one operation per cycle when out_ready is high.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake (a, b, op transfer on valid && ready)
//   a, b, op            : operands and operation select
//   out_valid, out_ready: output handshake (out, zero transfer on valid && ready)
//   out, zero           : registered result and result == 0 flag
module logicunit_pipe
  import logicunit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  op_t              s1_op_r;
  logic             s1_valid_r;
  logic [WIDTH-1:0] s2_out_r;
  logic             s2_zero_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] core_result_s;
  logic             s2_load_s;
  logic             in_fire_s;
  logic             out_fire_s;

  // S2 can take S1's content when it is empty or its result leaves this edge.
  assign s2_load_s  = s1_valid_r && (!s2_valid_r || out_ready);
  // S1 has room when empty, or when its content can move into S2 this edge.
  assign in_ready   = !s1_valid_r || !s2_valid_r || out_ready;
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = s2_valid_r && out_ready;

  logicunit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a_r),
    .b      (s1_b_r),
    .op     (s1_op_r),
    .result (core_result_s)
  );

  // Stage 1 register: operands, op and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_op_r    <= OP_AND;
      s1_valid_r <= 1'b0;
    end else if (in_fire_s) begin
      s1_a_r     <= a;
      s1_b_r     <= b;
      s1_op_r    <= op_t'(op);
      s1_valid_r <= 1'b1;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2 register: result, zero flag and occupancy; holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_out_r   <= {WIDTH{1'b0}};
      s2_zero_r  <= 1'b1;
      s2_valid_r <= 1'b0;
    end else if (s2_load_s) begin
      s2_out_r   <= core_result_s;
      s2_zero_r  <= ~|core_result_s;
      s2_valid_r <= 1'b1;
    end else if (out_fire_s) begin
      s2_valid_r <= 1'b0;
    end
  end

  assign out       = s2_out_r;
  assign zero      = s2_zero_r;
  assign out_valid = s2_valid_r;

endmodule

// File: tb/tb_logicunit_pipe.sv
// tb_logicunit_pipe: randomized self-checking bench for logicunit_pipe.
// A truth-table model predicts each accepted operation's result; a queue
// of in-flight results, stamped with their acceptance edge, defines what
// out, zero, out_valid and in_ready must be on every cycle.
module tb_logicunit_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = 3'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] dout;
  logic         zero;

  always #5 clk = ~clk;

  logicunit_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .zero      (zero)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Per-op truth table indexed by {a_bit, b_bit}.
  logic [3:0] tt [8];

  typedef struct {
    logic [W-1:0] res;
    int           stamp;
  } item_t;

  item_t        q[$];
  logic [W-1:0] out_log[$];
  logic         zero_log[$];
  int           lat_log[$];
  int           edge_log[$];
  int           edge_cnt = 0;
  int           acc_cnt = 0;

  logic         lat_in_fire = 1'b0;
  logic         lat_out_fire = 1'b0;
  logic [W-1:0] lat_res = '0;
  logic [W-1:0] lat_out = '0;
  logic         lat_zero = 1'b0;

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [2:0] o);
    logic [W-1:0] r;
    logic [3:0]   t;
    t = tt[o];
    for (int i = 0; i < W; i++) r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: check outputs against the model queue every cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out", 64'(dout), 64'd0);
      chk("rst_zero", {63'd0, zero}, 64'd1);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      lat_in_fire  <= 1'b0;
      lat_out_fire <= 1'b0;
    end else begin
      chk("out_valid", {63'd0, out_valid},
          {63'd0, (q.size() > 0 && q[0].stamp < edge_cnt)});
      if (out_valid && q.size() > 0) begin
        chk("out", 64'(dout), 64'(q[0].res));
        chk("zero", {63'd0, zero}, {63'd0, (q[0].res == '0)});
      end
      chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2) || out_ready});
      lat_in_fire  <= in_valid && in_ready;
      lat_out_fire <= out_valid && out_ready;
      lat_res      <= model(a, b, op);
      lat_out      <= dout;
      lat_zero     <= zero;
    end
  end

  // Model update at each edge: retire transferred result, enqueue accepted op.
  always @(posedge clk) begin
    edge_cnt++;
    if (!reset_n) begin
      q.delete();
    end else begin
      if (lat_out_fire && q.size() > 0) begin
        out_log.push_back(lat_out);
        zero_log.push_back(lat_zero);
        lat_log.push_back(edge_cnt - q[0].stamp);
        edge_log.push_back(edge_cnt);
        void'(q.pop_front());
      end
      if (lat_in_fire) begin
        item_t it;
        it.res   = lat_res;
        it.stamp = edge_cnt;
        q.push_back(it);
        acc_cnt++;
      end
    end
  end

  task automatic clear_logs();
    out_log.delete();
    zero_log.delete();
    lat_log.delete();
    edge_log.delete();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() > 0 || out_valid) && k < 200) begin
      next_cycle();
      k++;
    end
    next_cycle();
    chk(name, {63'd0, (k < 200)}, 64'd1);
  endtask

  initial begin
    logic [W-1:0] exp8 [8];
    int           acc0;
    int           prev;
    int           cyc;

    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0001;
    tt[4] = 4'b0100; tt[5] = 4'b1101; tt[6] = 4'b1100; tt[7] = 4'b0011;
    exp8[0] = 8'h00; exp8[1] = 8'hFF; exp8[2] = 8'hFF; exp8[3] = 8'h00;
    exp8[4] = 8'hC5; exp8[5] = 8'hC5; exp8[6] = 8'hC5; exp8[7] = 8'h3A;

    // Pin the model against hand-computed results.
    for (int i = 0; i < 8; i++)
      chk("model_pin", 64'(model(8'hC5, 8'h3A, 3'(i))), 64'(exp8[i]));

    // Reset held low.
    reset_n = 1'b0;
    repeat (3) next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // All ops back to back on C5/3A.
    clear_logs();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 8'hC5;
    b = 8'h3A;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      next_cycle();
    end
    drain("dir_drain");
    chk("dir_count", 64'(out_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) begin
      chk("dir_out", 64'(out_log[i]), 64'(exp8[i]));
      chk("dir_zero", {63'd0, zero_log[i]}, {63'd0, (i == 0 || i == 3)});
      chk("dir_latency", 64'(lat_log[i]), 64'd2);
    end

    // Back-to-back random stream of 16.
    clear_logs();
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      op = 3'($urandom_range(0, 7));
      next_cycle();
    end
    drain("b2b_drain");
    chk("b2b_count", 64'(out_log.size()), 64'd16);
    if (edge_log.size() == 16)
      chk("b2b_consecutive", 64'(edge_log[15] - edge_log[0]), 64'd15);

    // Backpressure: out_ready low for 5 cycles with in_valid high.
    clear_logs();
    acc0 = acc_cnt;
    prev = acc_cnt;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (acc_cnt != prev) begin
        prev = acc_cnt;
        a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
      end
    end
    chk("bp_accepted", 64'(acc_cnt - acc0), 64'd2);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    drain("bp_drain");
    chk("bp_delivered", 64'(out_log.size()), 64'd2);
    if (edge_log.size() == 2)
      chk("bp_one_per_cycle", 64'(edge_log[1] - edge_log[0]), 64'd1);

    // Random handshake toggling, 1000 ops.
    clear_logs();
    acc0 = acc_cnt;
    prev = acc_cnt;
    cyc  = 0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
    while (acc_cnt - acc0 < 1000 && cyc < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      next_cycle();
      cyc++;
      if (acc_cnt != prev) begin
        prev = acc_cnt;
        a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
      end
    end
    drain("rand_drain");
    chk("rand_accepted", 64'(acc_cnt - acc0), 64'd1000);
    chk("rand_delivered", 64'(out_log.size()), 64'd1000);

    // Edge values.
    clear_logs();
    in_valid = 1'b1;
    a = 8'hFF; b = 8'hFF; op = 3'd2;
    next_cycle();
    a = 8'h00; b = 8'h5A; op = 3'd7;
    next_cycle();
    drain("edge_drain");
    chk("edge_count", 64'(out_log.size()), 64'd2);
    if (out_log.size() == 2) begin
      chk("edge_xor_out", 64'(out_log[0]), 64'h00);
      chk("edge_xor_zero", {63'd0, zero_log[0]}, 64'd1);
      chk("edge_nota_out", 64'(out_log[1]), 64'hFF);
      chk("edge_nota_zero", {63'd0, zero_log[1]}, 64'd0);
    end

    // Mid-stream asynchronous reset with two ops in flight.
    clear_logs();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 8'h12; b = 8'h34; op = 3'd1;
    next_cycle();
    a = 8'h56; op = 3'd6;
    next_cycle();
    in_valid = 1'b0;
    chk("mid_both_full", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_out", 64'(dout), 64'd0);
    chk("async_zero", {63'd0, zero}, 64'd1);
    chk("async_in_ready", {63'd0, in_ready}, 64'd1);
    next_cycle();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (5) next_cycle();
    chk("mid_discarded", 64'(out_log.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
